// File: rtl/uart_cmd_arbiter.sv
// Round-robin arbiter sharing one UART command engine among N_REQ register-access requesters.
// Latency: grant one cycle after IDLE samples req_vld; response one cycle after the UART returns idle.
// Backpressure: requesters hold req_vld/req_cmd until req_rdy; one transaction in flight at a time.
// Optional build macro UART_ARB_TIMEOUT_EN compiles in the per-transaction timeout counter.
module uart_cmd_arbiter #(
    parameter int N_REQ      = 4,
    parameter int CMD_WIDTH  = 16,
    parameter int READ_WIDTH = 8,
    parameter int TIMEOUT    = 60000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_vld,
    input  logic [N_REQ*CMD_WIDTH-1:0]    req_cmd,
    output logic [N_REQ-1:0]              req_rdy,
    output logic [N_REQ-1:0]              rsp_vld,
    output logic [READ_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic                          busy,
    output logic [$clog2(N_REQ)-1:0]      gnt_id,
    output logic [CMD_WIDTH-1:0]          u_cmd_in,
    output logic                          u_cmd_vld,
    input  logic                          u_cmd_rdy,
    input  logic                          u_read_rdy,
    input  logic [READ_WIDTH-1:0]         u_read_data
);

    localparam int IDW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                state;
    logic [IDW-1:0]        rr_ptr;
    logic                  is_write;
    logic                  got;
    logic [READ_WIDTH-1:0] rd_buf;

    logic                  pick_vld;
    logic [IDW-1:0]        pick_idx;
    logic [IDW-1:0]        nxt_ptr;
    logic [CMD_WIDTH-1:0]  pick_cmd;
    logic [N_REQ-1:0]      pick_oh;
    logic [N_REQ-1:0]      gnt_oh;
    logic                  tmo_hit;

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
    // Walking the offsets downwards lets the smallest offset overwrite the rest.
    always_comb begin
        int j;
        pick_vld = 1'b0;
        pick_idx = '0;
        j        = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (req_vld[j]) begin
                pick_vld = 1'b1;
                pick_idx = IDW'(j);
            end
        end
    end

    // Command of the picked requester, its one-hot, and the pointer that follows it.
    always_comb begin
        pick_cmd = req_cmd[int'(pick_idx)*CMD_WIDTH +: CMD_WIDTH];
        pick_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
        gnt_oh   = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_id;
        if (int'(pick_idx) == N_REQ - 1) begin
            nxt_ptr = '0;
        end else begin
            nxt_ptr = pick_idx + IDW'(1);
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    // Transaction age: held at zero in IDLE so it starts from zero on entry to ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == S_IDLE) begin
            tmo_cnt <= '0;
        end else if (state == S_ISSUE || state == S_WAIT) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    assign tmo_hit = (state == S_ISSUE || state == S_WAIT) &&
                     (tmo_cnt == 16'(TIMEOUT - 1));
`else
    // Without the counter the engine waits for the UART indefinitely.
    assign tmo_hit = 1'b0;
`endif

    // Transaction FSM; every output is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            is_write  <= 1'b0;
            got       <= 1'b0;
            rd_buf    <= '0;
            req_rdy   <= '0;
            rsp_vld   <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            gnt_id    <= '0;
            u_cmd_in  <= '0;
            u_cmd_vld <= 1'b0;
        end else begin
            req_rdy <= '0;
            rsp_vld <= '0;
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        gnt_id    <= pick_idx;
                        u_cmd_in  <= pick_cmd;
                        is_write  <= pick_cmd[CMD_WIDTH-1];
                        req_rdy   <= pick_oh;
                        u_cmd_vld <= 1'b1;
                        busy      <= 1'b1;
                        rr_ptr    <= nxt_ptr;
                        got       <= 1'b0;
                        rd_buf    <= '0;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // The UART going busy is acceptance, not completion, so a
                    // timeout in the same cycle still takes effect.
                    if (tmo_hit) begin
                        u_cmd_vld <= 1'b0;
                        rsp_vld   <= gnt_oh;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        state     <= S_RESP;
                    end else if (!u_cmd_rdy) begin
                        u_cmd_vld <= 1'b0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!is_write && u_read_rdy) begin
                        rd_buf <= u_read_data;
                        got    <= 1'b1;
                    end
                    // Completion beats a coincident timeout.
                    if (u_cmd_rdy) begin
                        rsp_vld <= gnt_oh;
                        if (is_write) begin
                            rsp_data <= '0;
                            rsp_err  <= 1'b0;
                        end else if (u_read_rdy) begin
                            rsp_data <= u_read_data;
                            rsp_err  <= 1'b0;
                        end else begin
                            rsp_data <= got ? rd_buf : '0;
                            rsp_err  <= !got;
                        end
                        state <= S_RESP;
                    end else if (tmo_hit) begin
                        rsp_vld  <= gnt_oh;
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    // rsp_vld was pulsed on entry; clear the payload behind it.
                    rsp_data <= '0;
                    rsp_err  <= 1'b0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_arbiter.sv
// Scoreboard bench for uart_cmd_arbiter: randomized batches of requests against a
// queue-based round-robin model, a scripted UART, and directed read/write/reset cases.
// Optional build macro UART_ARB_TIMEOUT_EN enables the timeout scenario.
module tb_uart_cmd_arbiter;

    localparam int N  = 4;
    localparam int CW = 16;
    localparam int RW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_vld;
    logic [N*CW-1:0] req_cmd;
    logic [N-1:0]    req_rdy;
    logic [N-1:0]    rsp_vld;
    logic [RW-1:0]   rsp_data;
    logic            rsp_err;
    logic            busy;
    logic [1:0]      gnt_id;
    logic [CW-1:0]   u_cmd_in;
    logic            u_cmd_vld;
    logic            u_cmd_rdy;
    logic            u_read_rdy;
    logic [RW-1:0]   u_read_data;

    always #5 clk = ~clk;

    uart_cmd_arbiter #(
        .N_REQ(N), .CMD_WIDTH(CW), .READ_WIDTH(RW), .TIMEOUT(100)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_cmd(req_cmd), .req_rdy(req_rdy),
        .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .gnt_id(gnt_id),
        .u_cmd_in(u_cmd_in), .u_cmd_vld(u_cmd_vld), .u_cmd_rdy(u_cmd_rdy),
        .u_read_rdy(u_read_rdy), .u_read_data(u_read_data)
    );

    typedef struct { int id; logic [CW-1:0] cmd; } gnt_t;
    typedef struct { int id; logic [RW-1:0] data; logic err; } rsp_t;

    gnt_t exp_gnt[$];
    rsp_t exp_rsp[$];
    gnt_t mg;
    rsp_t mr;

    int tests = 0;
    int fails = 0;

    int            model_ptr;
    logic [CW-1:0] cmd_tab[N][4];
    int            force_mode;   // -1 random UART behaviour, 0 read returns 0xA5, 1 read returns nothing

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT grants or responds.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (req_rdy != '0) begin
                if (exp_gnt.size() == 0) begin
                    chk("unexpected_grant", 32'(req_rdy), 32'd0);
                end else begin
                    mg = exp_gnt.pop_front();
                    chk("grant_onehot", 32'(req_rdy), 32'd1 << mg.id);
                    chk("gnt_id", 32'(gnt_id), 32'(mg.id));
                    chk("u_cmd_in", 32'(u_cmd_in), 32'(mg.cmd));
                    chk("u_cmd_vld_at_grant", 32'(u_cmd_vld), 32'd1);
                end
            end
            if (rsp_vld != '0) begin
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_vld), 32'd0);
                end else begin
                    mr = exp_rsp.pop_front();
                    chk("rsp_onehot", 32'(rsp_vld), 32'd1 << mr.id);
                    chk("rsp_data", 32'(rsp_data), 32'(mr.data));
                    chk("rsp_err", 32'(rsp_err), 32'(mr.err));
                    chk("busy_in_resp", 32'(busy), 32'd1);
                end
            end
        end
    end

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (u_cmd_vld === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL grant_wait: u_cmd_vld still low after 300 cycles, required high");
        end
    endtask

    // Scripted UART: caller has just pulled u_cmd_rdy low one step after an edge.
    task automatic serve(input int id, input logic [CW-1:0] cmd);
        bit            give;
        logic [RW-1:0] d;
        rsp_t          e;
        int            n;
        give = (force_mode < 0) ? ($urandom_range(0, 3) != 0) : (force_mode == 0);
        d    = (force_mode < 0) ? RW'($urandom) : 8'hA5;
        e.id = id;
        if (cmd[CW-1]) begin
            e.data = '0; e.err = 1'b0;
        end else if (give) begin
            e.data = d;  e.err = 1'b0;
        end else begin
            e.data = '0; e.err = 1'b1;
        end
        exp_rsp.push_back(e);
        @(posedge clk); #1;
        // A write may see a stray read pulse; it must not leak into the response.
        if ((!cmd[CW-1] && give) || (cmd[CW-1] && $urandom_range(0, 1) == 1)) begin
            u_read_rdy  = 1'b1;
            u_read_data = d;
        end
        @(posedge clk); #1;
        u_read_rdy  = 1'b0;
        u_read_data = RW'($urandom);
        n = $urandom_range(0, 3);
        repeat (n) begin
            @(posedge clk); #1;
        end
        u_cmd_rdy = 1'b1;
    endtask

    // All requesters in mask stay valid for 'rounds' commands each; the model
    // grant order is the mask walked cyclically from the model pointer.
    task automatic run_batch(input logic [N-1:0] mask, input int rounds);
        int   total;
        int   p;
        int   cnt[N];
        int   ord[$];
        gnt_t g;
        bit   ok;
        total = $countones(mask) * rounds;
        p = model_ptr;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        while (ord.size() < total) begin
            if (mask[p]) begin
                g.id  = p;
                g.cmd = cmd_tab[p][cnt[p]];
                cnt[p]++;
                exp_gnt.push_back(g);
                ord.push_back(p);
            end
            p = (p + 1) % N;
        end
        model_ptr = p;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            if (mask[i]) begin
                req_cmd[i*CW +: CW] = cmd_tab[i][0];
                req_vld[i] = 1'b1;
            end
        end
        foreach (ord[k]) begin
            int id;
            id = ord[k];
            wait_grant(ok);
            if (!ok) begin
                req_vld = '0;
                return;
            end
            @(posedge clk); #1;
            cnt[id]++;
            if (cnt[id] < rounds) req_cmd[id*CW +: CW] = cmd_tab[id][cnt[id]];
            else                  req_vld[id] = 1'b0;
            u_cmd_rdy = 1'b0;
            serve(id, cmd_tab[id][cnt[id]-1]);
        end
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!busy && exp_rsp.size() == 0) break;
        end
        chk("rsp_drained", 32'(exp_rsp.size()), 32'd0);
        chk("gnt_drained", 32'(exp_gnt.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_rdy"},   32'(req_rdy),   32'd0);
        chk({tag, "_rsp_vld"},   32'(rsp_vld),   32'd0);
        chk({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
        chk({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_gnt_id"},    32'(gnt_id),    32'd0);
        chk({tag, "_u_cmd_in"},  32'(u_cmd_in),  32'd0);
        chk({tag, "_u_cmd_vld"}, 32'(u_cmd_vld), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        gnt_t g;
        bit   ok;
        rst_n = 1'b0;
        req_vld = '0; req_cmd = '0;
        u_cmd_rdy = 1'b1; u_read_rdy = 1'b0; u_read_data = '0;
        model_ptr = 0; force_mode = -1;
        #1;
        chk_all_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write from requester 0.
        cmd_tab[0][0] = 16'h8123;
        run_batch(4'b0001, 1);
        // Single read from requester 2 returning 0xA5.
        cmd_tab[2][0] = 16'h0045;
        force_mode = 0;
        run_batch(4'b0100, 1);
        // Read where the UART goes idle without returning data.
        cmd_tab[1][0] = 16'h0033;
        force_mode = 1;
        run_batch(4'b0010, 1);

        // Randomized batches.
        force_mode = -1;
        repeat (25) begin
            for (int i = 0; i < N; i++)
                for (int r = 0; r < 4; r++)
                    cmd_tab[i][r] = CW'($urandom);
            run_batch(N'($urandom_range(1, 15)), $urandom_range(1, 3));
        end

`ifdef UART_ARB_TIMEOUT_EN
        // UART never accepts: the transaction must time out 100 cycles after grant.
        begin
            int lat;
            rsp_t e;
            g.id = 1; g.cmd = 16'h8777;
            exp_gnt.push_back(g);
            e.id = 1; e.data = '0; e.err = 1'b1;
            exp_rsp.push_back(e);
            req_cmd[1*CW +: CW] = 16'h8777;
            req_vld[1] = 1'b1;
            wait_grant(ok);
            @(posedge clk); #1;
            req_vld[1] = 1'b0;
            lat = -1;
            for (int c = 1; c <= 200; c++) begin
                @(negedge clk);
                if (rsp_vld != '0) begin
                    lat = c;
                    break;
                end
            end
            chk("timeout_latency", 32'(lat), 32'd100);
            chk("timeout_cmd_vld", 32'(u_cmd_vld), 32'd0);
            @(negedge clk);
            chk("timeout_idle", 32'(busy), 32'd0);
            model_ptr = 2;
        end
`endif

        // Reset while the UART is busy: the transaction vanishes silently.
        g.id = 2; g.cmd = 16'h0011;
        exp_gnt.push_back(g);
        req_cmd[2*CW +: CW] = 16'h0011;
        req_vld[2] = 1'b1;
        wait_grant(ok);
        @(posedge clk); #1;
        req_vld[2] = 1'b0;
        u_cmd_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_rsp", 32'(rsp_vld), 32'd0);
        u_cmd_rdy = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;

        // Fairness after reset: all four held valid for two rounds -> 0,1,2,3,0,1,2,3.
        for (int i = 0; i < N; i++)
            for (int r = 0; r < 2; r++)
                cmd_tab[i][r] = CW'(16'h8100 + i * 16 + r);
        run_batch(4'b1111, 2);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
